usb_rx_bit_frontend: RTL and testbench

Receive bit front end for the USB full-speed receive path. It runs at 8x the bit rate and takes the already-synchronized D+/D- line samples. It recovers bit timing from D+ transitions, NRZI-decodes the line, removes stuffed bits and flags SE0 (end of packet). Its outputs are serial_out plus a one-cycle shift_enable strobe, which feed the receive serial-to-parallel shift register directly (LSB-first configuration, reset value all ones).

---
 rtl/usb_rx_bit_frontend.sv | 149 ++++++++++++++
 tb/tb_usb_rx_bit_frontend.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/usb_rx_bit_frontend.sv
// USB full-speed receive bit front end: D+ edge-based bit timing recovery,
// NRZI decode, stuff-bit removal and SE0 (end-of-packet) detection.
module usb_rx_bit_frontend #(
    parameter int CLKS_PER_BIT = 8,
    parameter int SAMPLE_PHASE = 3,
    parameter int STUFF_LEN    = 6
) (
    input  logic clk,
    input  logic n_rst,
    input  logic d_plus_sync,
    input  logic d_minus_sync,
    output logic serial_out,
    output logic shift_enable,
    output logic eop,
    output logic bit_stuff_err,
    output logic rx_active
);

    localparam int CNT_W  = $clog2(CLKS_PER_BIT);
    localparam int ONES_W = $clog2(STUFF_LEN + 1);

    localparam logic [CNT_W-1:0]  CNT_ZERO   = CNT_W'(0);
    localparam logic [CNT_W-1:0]  CNT_ONE    = CNT_W'(1);
    localparam logic [CNT_W-1:0]  CNT_LAST   = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0]  CNT_SAMPLE = CNT_W'(SAMPLE_PHASE);
    localparam logic [ONES_W-1:0] ONES_ZERO  = ONES_W'(0);
    localparam logic [ONES_W-1:0] ONES_ONE   = ONES_W'(1);
    localparam logic [ONES_W-1:0] ONES_STUFF = ONES_W'(STUFF_LEN);

    typedef enum logic [1:0] {
        S_IDLE     = 2'd0,
        S_ACTIVE   = 2'd1,
        S_EOP_WAIT = 2'd2
    } state_t;

    state_t              state_q;
    logic [CNT_W-1:0]    cnt_q;
    logic [ONES_W-1:0]   ones_cnt_q;
    logic                d_plus_prev_q;
    logic                prev_sample_q;
    logic                serial_out_q;
    logic                shift_enable_q;
    logic                eop_q;
    logic                bit_stuff_err_q;
    logic                rx_active_q;

    logic edge_s;
    logic fall_s;
    logic sample_s;
    logic se0_s;
    logic j_s;
    logic decoded_s;

    assign edge_s    = (d_plus_sync != d_plus_prev_q);
    assign fall_s    = d_plus_prev_q & ~d_plus_sync;
    assign sample_s  = (cnt_q == CNT_SAMPLE);
    assign se0_s     = ~d_plus_sync & ~d_minus_sync;
    assign j_s       = d_plus_sync & ~d_minus_sync;
    assign decoded_s = (d_plus_sync == prev_sample_q);

    assign serial_out    = serial_out_q;
    assign shift_enable  = shift_enable_q;
    assign eop           = eop_q;
    assign bit_stuff_err = bit_stuff_err_q;
    assign rx_active     = rx_active_q;

    // Receive FSM: phase counter, NRZI/stuff tracking and registered strobes.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state_q         <= S_IDLE;
            cnt_q           <= CNT_ZERO;
            ones_cnt_q      <= ONES_ZERO;
            d_plus_prev_q   <= 1'b1;
            prev_sample_q   <= 1'b1;
            serial_out_q    <= 1'b1;
            shift_enable_q  <= 1'b0;
            eop_q           <= 1'b0;
            bit_stuff_err_q <= 1'b0;
            rx_active_q     <= 1'b0;
        end else begin
            d_plus_prev_q   <= d_plus_sync;
            shift_enable_q  <= 1'b0;
            eop_q           <= 1'b0;
            bit_stuff_err_q <= 1'b0;

            case (state_q)
                S_IDLE: begin
                    cnt_q <= CNT_ZERO;
                    // Only a J->K transition (D+ falling) can start a packet.
                    if (fall_s) begin
                        state_q       <= S_ACTIVE;
                        cnt_q         <= CNT_ONE;
                        rx_active_q   <= 1'b1;
                        ones_cnt_q    <= ONES_ZERO;
                        prev_sample_q <= 1'b1;
                    end
                end

                S_ACTIVE, S_EOP_WAIT: begin
                    if (edge_s) begin
                        cnt_q <= CNT_ONE;
                    end else if (cnt_q == CNT_LAST) begin
                        cnt_q <= CNT_ZERO;
                    end else begin
                        cnt_q <= cnt_q + CNT_ONE;
                    end

                    if (sample_s) begin
                        if (state_q == S_ACTIVE) begin
                            if (se0_s) begin
                                eop_q   <= 1'b1;
                                state_q <= S_EOP_WAIT;
                            end else begin
                                prev_sample_q <= d_plus_sync;
                                if (ones_cnt_q == ONES_STUFF) begin
                                    ones_cnt_q      <= ONES_ZERO;
                                    bit_stuff_err_q <= decoded_s;
                                end else begin
                                    serial_out_q   <= decoded_s;
                                    shift_enable_q <= 1'b1;
                                    ones_cnt_q     <= decoded_s ? (ones_cnt_q + ONES_ONE) : ONES_ZERO;
                                end
                            end
                        end else begin
                            if (se0_s) begin
                                eop_q <= 1'b1;
                            end else if (j_s) begin
                                state_q       <= S_IDLE;
                                rx_active_q   <= 1'b0;
                                ones_cnt_q    <= ONES_ZERO;
                                prev_sample_q <= 1'b1;
                            end else begin
                                state_q <= S_EOP_WAIT;
                            end
                        end
                    end
                end

                default: begin
                    state_q     <= S_IDLE;
                    cnt_q       <= CNT_ZERO;
                    ones_cnt_q  <= ONES_ZERO;
                    rx_active_q <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_usb_rx_bit_frontend.sv
// Directed bench for usb_rx_bit_frontend: NRZI line driver with an expected-strobe
// scoreboard (kind, bit value, cycle) checked by a negedge monitor.
module tb_usb_rx_bit_frontend;

    localparam int K_NONE = 0;
    localparam int K_DATA = 1;
    localparam int K_EOP  = 2;
    localparam int K_ERR  = 3;

    logic clk = 1'b0;
    logic n_rst;
    logic d_plus_sync;
    logic d_minus_sync;
    logic serial_out;
    logic shift_enable;
    logic eop;
    logic bit_stuff_err;
    logic rx_active;

    usb_rx_bit_frontend #(
        .CLKS_PER_BIT (8),
        .SAMPLE_PHASE (3),
        .STUFF_LEN    (6)
    ) dut (
        .clk           (clk),
        .n_rst         (n_rst),
        .d_plus_sync   (d_plus_sync),
        .d_minus_sync  (d_minus_sync),
        .serial_out    (serial_out),
        .shift_enable  (shift_enable),
        .eop           (eop),
        .bit_stuff_err (bit_stuff_err),
        .rx_active     (rx_active)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int   kind;
        logic b;
        int   cyc;
    } exp_t;

    exp_t       sb[$];
    exp_t       m;
    int         vectors    = 0;
    int         miscompares = 0;
    logic [7:0] sr;
    logic       lvl;
    int         last_samp = 0;
    int         obs_kind;

    task automatic chk(input string tag, input int obs, input int expv);
        vectors++;
        assert (obs === expv) else begin
            miscompares++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, expv);
        end
    endtask

    // Drive one bit period; a D+ change resyncs the sample to 4 clks later,
    // otherwise the sample follows the previous one by a full bit period.
    task automatic drive(input logic dp, input logic dm, input int len, input int kind, input logic b);
        exp_t e;
        int   samp;
        samp      = (dp != d_plus_sync) ? cyc + 4 : last_samp + 8;
        last_samp = samp;
        if (kind != K_NONE) begin
            e.kind = kind;
            e.b    = b;
            e.cyc  = samp;
            sb.push_back(e);
        end
        d_plus_sync  = dp;
        d_minus_sync = dm;
        lvl          = dp;
        repeat (len) @(posedge clk);
        #1;
    endtask

    task automatic send_bit(input logic b, input int len, input int kind);
        logic dp;
        dp = b ? lvl : ~lvl;
        drive(dp, ~dp, len, kind, b);
    endtask

    task automatic send_sync();
        for (int i = 0; i < 7; i++) send_bit(1'b0, 8, K_DATA);
        send_bit(1'b1, 8, K_DATA);
    endtask

    task automatic send_eop();
        drive(1'b0, 1'b0, 8, K_EOP, 1'b0);
        drive(1'b0, 1'b0, 8, K_EOP, 1'b0);
        chk("rx_active_in_eop", int'(rx_active), 1);
        drive(1'b1, 1'b0, 8, K_NONE, 1'b0);
        chk("rx_active_after_j", int'(rx_active), 0);
    endtask

    initial begin
        n_rst        = 1'b0;
        d_plus_sync  = 1'b1;
        d_minus_sync = 1'b0;
        lvl          = 1'b1;
        sr           = 8'hFF;

        fork
            forever begin
                @(negedge clk);
                if (n_rst === 1'b1 && (shift_enable | eop | bit_stuff_err) === 1'b1) begin
                    obs_kind = shift_enable ? K_DATA : (eop ? K_EOP : K_ERR);
                    chk("one_hot", int'(shift_enable) + int'(eop) + int'(bit_stuff_err), 1);
                    if (sb.size() == 0) begin
                        chk("unexpected_strobe", obs_kind, K_NONE);
                    end else begin
                        m = sb.pop_front();
                        chk("strobe_kind", obs_kind, m.kind);
                        chk("strobe_cycle", cyc, m.cyc);
                        if (m.kind == K_DATA) chk("serial_out", int'(serial_out), int'(m.b));
                    end
                    if (shift_enable) sr = {serial_out, sr[7:1]};
                end
            end
        join_none

        // Reset values
        repeat (2) @(posedge clk);
        #1;
        chk("rst_serial_out", int'(serial_out), 1);
        chk("rst_shift_enable", int'(shift_enable), 0);
        chk("rst_eop", int'(eop), 0);
        chk("rst_bit_stuff_err", int'(bit_stuff_err), 0);
        chk("rst_rx_active", int'(rx_active), 0);
        n_rst = 1'b1;
        drive(1'b1, 1'b0, 10, K_NONE, 1'b0);
        chk("idle_rx_active", int'(rx_active), 0);

        // SYNC, then stuff removal: 0, six 1s, stuff 0, 1, 0
        send_sync();
        chk("sync_shreg", int'(sr), 8'h80);
        chk("sync_rx_active", int'(rx_active), 1);
        send_bit(1'b0, 8, K_DATA);
        for (int i = 0; i < 6; i++) send_bit(1'b1, 8, K_DATA);
        send_bit(1'b0, 8, K_NONE);
        send_bit(1'b1, 8, K_DATA);
        send_bit(1'b0, 8, K_DATA);
        chk("stuff_shreg", int'(sr), 8'h7F);

        // Stuff error: seven decoded 1s
        for (int i = 0; i < 6; i++) send_bit(1'b1, 8, K_DATA);
        send_bit(1'b1, 8, K_ERR);
        chk("stufferr_rx_active", int'(rx_active), 1);

        // Jitter: 7-clk bit then 9-clk bit
        send_bit(1'b0, 7, K_DATA);
        send_bit(1'b0, 9, K_DATA);
        send_bit(1'b1, 8, K_DATA);
        send_bit(1'b0, 8, K_DATA);

        send_eop();
        drive(1'b1, 1'b0, 16, K_NONE, 1'b0);
        chk("pkt1_all_strobes_seen", sb.size(), 0);

        // Reset in the middle of a packet
        send_bit(1'b0, 8, K_DATA);
        send_bit(1'b0, 8, K_DATA);
        drive(~lvl, lvl, 2, K_NONE, 1'b0);
        #2;
        n_rst = 1'b0;
        #1;
        chk("midrst_serial_out", int'(serial_out), 1);
        chk("midrst_shift_enable", int'(shift_enable), 0);
        chk("midrst_eop", int'(eop), 0);
        chk("midrst_bit_stuff_err", int'(bit_stuff_err), 0);
        chk("midrst_rx_active", int'(rx_active), 0);
        chk("midrst_pending", sb.size(), 0);
        sb.delete();
        sr           = 8'hFF;
        d_plus_sync  = 1'b1;
        d_minus_sync = 1'b0;
        lvl          = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        n_rst = 1'b1;
        repeat (4) @(posedge clk);
        #1;
        chk("postrst_rx_active", int'(rx_active), 0);

        // New packet after reset
        send_sync();
        chk("resync_shreg", int'(sr), 8'h80);
        chk("resync_rx_active", int'(rx_active), 1);
        send_bit(1'b1, 8, K_DATA);
        send_bit(1'b0, 8, K_DATA);
        send_eop();
        drive(1'b1, 1'b0, 16, K_NONE, 1'b0);
        chk("pkt2_all_strobes_seen", sb.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
